// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX operand forwarding selects and load-use stall sequencer (optional stats via FWD_STATS_EN)
module fwd_hazard_ctrl #(
   parameter int LOAD_STALL_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic [4:0]  id_ex_rs1,
   input  logic [4:0]  id_ex_rs2,
   input  logic [4:0]  id_ex_rd,
   input  logic        id_ex_mem_read,
   input  logic [4:0]  ex_mem_rd,
   input  logic        ex_mem_reg_write,
   input  logic [4:0]  mem_wb_rd,
   input  logic        mem_wb_reg_write,
   input  logic        flush,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
   output logic        stall,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        id_ex_bubble,
   output logic [31:0] stall_count,
   output logic [31:0] fwd_count
);

   typedef enum logic [0:0] {IDLE, STALL} state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [1:0]  r_cnt;
   logic [1:0]  w_next_cnt;
   logic        w_hazard;
   logic        w_stall;
   logic [1:0]  w_fwd_a;
   logic [1:0]  w_fwd_b;

   // Forward select for operand A: the younger producer in EX/MEM wins over MEM/WB; x0 never forwards
   always_comb begin
      w_fwd_a = 2'b00;
      if (!rst) begin
         if (ex_mem_reg_write && (ex_mem_rd != 5'd0) && (ex_mem_rd == id_ex_rs1))
            w_fwd_a = 2'b01;
         else if (mem_wb_reg_write && (mem_wb_rd != 5'd0) && (mem_wb_rd == id_ex_rs1))
            w_fwd_a = 2'b10;
      end
   end

   // Forward select for operand B, same priority rule as operand A
   always_comb begin
      w_fwd_b = 2'b00;
      if (!rst) begin
         if (ex_mem_reg_write && (ex_mem_rd != 5'd0) && (ex_mem_rd == id_ex_rs2))
            w_fwd_b = 2'b01;
         else if (mem_wb_reg_write && (mem_wb_rd != 5'd0) && (mem_wb_rd == id_ex_rs2))
            w_fwd_b = 2'b10;
      end
   end

   assign w_hazard = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                     ((id_ex_rd == id_rs1) || (id_ex_rd == id_rs2));

   // Stall state register; reset aborts any stall in progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 2'd0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
      end
   end

   // Next-state and stall decode; the first stall cycle comes from IDLE, extra cycles are counted in STALL
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_stall      = 1'b0;
      case (r_state)
         IDLE: begin
            w_stall = w_hazard && !flush;
            if (w_stall && (LOAD_STALL_CYCLES > 1)) begin
               w_next_state = STALL;
               w_next_cnt   = 2'(LOAD_STALL_CYCLES - 1);
            end
         end
         STALL: begin
            w_stall    = !flush;
            w_next_cnt = r_cnt - 2'd1;
            if (r_cnt == 2'd1)
               w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
            w_next_cnt   = 2'd0;
         end
      endcase
      if (flush) begin
         w_next_state = IDLE;
         w_next_cnt   = 2'd0;
      end
   end

   assign fwd_a        = w_fwd_a;
   assign fwd_b        = w_fwd_b;
   assign stall        = w_stall && !rst;
   assign pc_write     = !stall;
   assign if_id_write  = !stall;
   assign id_ex_bubble = stall;

`ifdef FWD_STATS_EN
   logic [31:0] r_stall_count;
   logic [31:0] r_fwd_count;

   // Saturating activity counters, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_count <= 32'd0;
         r_fwd_count   <= 32'd0;
      end else begin
         if (stall && (r_stall_count != 32'hFFFF_FFFF))
            r_stall_count <= r_stall_count + 32'd1;
         if (((w_fwd_a != 2'b00) || (w_fwd_b != 2'b00)) && (r_fwd_count != 32'hFFFF_FFFF))
            r_fwd_count <= r_fwd_count + 32'd1;
      end
   end

   assign stall_count = r_stall_count;
   assign fwd_count   = r_fwd_count;
`else
   assign stall_count = 32'd0;
   assign fwd_count   = 32'd0;
`endif

endmodule
